bcd_digit_serial_sequencer: RTL
===============================

Name: bcd_digit_serial_sequencer

Overview:
Sequences one shared single-digit BCD adder (4-bit a/b, cin → 4-bit s, cout) across a multi-digit addition, least-significant digit first, one digit per clock. It accepts two packed BCD operands through a start/ready handshake. It drives the adder's digit inputs, collects the digit sums and the ripple carry, and presents the full result under a valid/ack handshake. It sits between the switch/key front end and the existing combinational BCD adder on the DE10-Lite top level.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1..8
IDX_W, 3, width of the digit index counter; must satisfy 2^IDX_W >= DIGITS

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin an addition; accepted only when ready=1
op_a  input  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]
op_b  input  4*DIGITS  operand B, packed BCD
cin  input  1  initial carry into digit 0
ready  output  1  high in IDLE only
dig_a  output  4  to the adder's a input
dig_b  output  4  to the adder's b input
dig_cin  output  1  to the adder's cin input
dig_s  input  4  from the adder's s output; combinational, same cycle
dig_cout  input  1  from the adder's cout output
result_valid  output  1  high in DONE
result_sum  output  4*DIGITS  packed BCD sum
result_cout  output  1  carry out of the most-significant digit
result_ack  input  1  consumer acknowledge
err  output  1  an operand digit > 9 was seen, or the adder returned dig_s > 9
busy  output  1  high in RUN

Behaviour:
- Reset, asynchronous and active-high:
  - state goes to IDLE.
  - ready=1, busy=0, result_valid=0, result_sum=0, result_cout=0, err=0, dig_a=0, dig_b=0, dig_cin=0.
  - The index counter, carry register and operand registers clear.
  - Reset mid-RUN or mid-DONE aborts immediately. No partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1 at a clock edge: latch op_a, op_b into registers; carry_reg<=cin; idx<=0; clear result_sum; go to RUN.
  - err <= 1 if any of the 2*DIGITS operand nibbles is > 9; otherwise err <= 0.
  - start=0: remain in IDLE.
- RUN (busy=1, ready=0):
  - Combinationally, dig_a = a_reg digit[idx], dig_b = b_reg digit[idx], dig_cin = carry_reg.
  - Each edge: result_sum digit[idx] <= dig_s; carry_reg <= dig_cout.
  - If dig_s > 9, set err (sticky until next accept).
  - If idx == DIGITS-1: result_cout <= dig_cout and go to DONE. Otherwise idx <= idx+1.
  - Exactly DIGITS cycles are spent in RUN.
  - start is ignored while in RUN.
- In IDLE and DONE, dig_a, dig_b and dig_cin are 0.
- DONE:
  - result_valid=1. result_sum, result_cout and err are held stable.
  - On result_ack=1: go to IDLE. result_valid drops the next cycle; result_sum, result_cout and err keep their values until the next accept.
  - start is ignored in DONE; ready=0. A start asserted in the same cycle as the ack is not accepted and must be re-presented in IDLE.
  - result_ack outside DONE has no effect.
- Latency: accept edge at cycle 0; result_valid=1 from cycle DIGITS+1. Minimum back-to-back period is DIGITS+2 cycles, with ack held high.
- Invalid BCD operands are still processed. The result is whatever the adder returns, with err=1.
- All outputs other than dig_a, dig_b and dig_cin are registered.

Test Plan:
1. DIGITS=4, op_a=0x1234, op_b=0x5678, cin=0, start one cycle, ack low → ready drops; busy for exactly 4 cycles; result_valid at cycle 5; result_sum=0x6912, result_cout=0, err=0; values hold while ack=0 for 10 cycles.
2. Carry ripple: op_a=0x9999, op_b=0x0001, cin=0 → dig_cin sequence 0,1,1,1; result_sum=0x0000, result_cout=1. Also op_a=0x0000, op_b=0x0000, cin=1 → result_sum=0x0001, result_cout=0.
3. Invalid operand: op_a=0x12A4, op_b=0x0000 → err=1 from the cycle after accept; completion is still signalled after 4 RUN cycles. Next accept with valid operands → err=0.
4. Handshake: start held high continuously with ack pulsed in DONE → a new accept only on IDLE cycles; start together with ack in DONE is not accepted. A result_ack pulse in IDLE/RUN → no state change.
5. Reset mid-operation: assert reset asynchronously (between clock edges) at RUN idx=2 → all outputs zero and ready=1 immediately, with no result_valid pulse. A fresh 0x0005+0x0005 then gives 0x0010, cout=0.
6. Bench with a behavioural BCD adder model: 500 random valid operand pairs plus random cin → result equals a decimal reference; err=0 throughout.

Source files
------------

// File: rtl/bcd_digit_serial_sequencer.sv
// Drives one shared single-digit BCD adder across a multi-digit add,
// least-significant digit first, with start/ready and valid/ack handshakes.
module bcd_digit_serial_sequencer #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] op_a,
    input  logic [4*DIGITS-1:0] op_b,
    input  logic                cin,
    output logic                ready,
    output logic [3:0]          dig_a,
    output logic [3:0]          dig_b,
    output logic                dig_cin,
    input  logic [3:0]          dig_s,
    input  logic                dig_cout,
    output logic                result_valid,
    output logic [4*DIGITS-1:0] result_sum,
    output logic                result_cout,
    input  logic                result_ack,
    output logic                err,
    output logic                busy
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [3:0]       sel_a, sel_b;
    logic             last;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_a = a_q[i*4 +: 4];
                sel_b = b_q[i*4 +: 4];
            end
        end
    end

    assign last    = (idx_q == IDX_W'(DIGITS - 1));
    assign dig_a   = (state_q == S_RUN) ? sel_a : 4'd0;
    assign dig_b   = (state_q == S_RUN) ? sel_b : 4'd0;
    assign dig_cin = (state_q == S_RUN) ? carry_q : 1'b0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = has_bad_digit(op_a) | has_bad_digit(op_b);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*4 +: 4] = dig_s;
                    end
                end
                carry_d = dig_cout;
                if (dig_s > 4'd9) begin
                    err_d = 1'b1;
                end
                if (last) begin
                    cout_d  = dig_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status flags are decoded from the next state so they leave a flop.
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result_sum   = sum_q;
    assign result_cout  = cout_q;
    assign err          = err_q;
endmodule
